// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line-fetch block.
// The color-bar table is only used when VGA_FETCH_TESTPAT_EN is defined.
package vga_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFull,
    StDrain
  } fill_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PIX_PER_WORD   = 2;

  // Colors are {B,G,R}, 4 bits each
  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'h0FF;
  localparam logic [11:0] BAR_CYAN    = 12'hFF0;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'h00F;
  localparam logic [11:0] BAR_BLUE    = 12'hF00;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_line_fetch_if.sv
// Read-request bus between the line-fetch controller (master) and the memory port (slave).
interface vga_line_fetch_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_gnt,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_gnt,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/vga_line_buf.sv
// Double line buffer: 1W1R synchronous RAM addressed {sel, word}, two 12-bit pixels per entry.
// A same-cycle write to the read address is forwarded so a just-completed line reads correctly.
module vga_line_buf #(
  parameter int unsigned LINE_WORDS = 512
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(LINE_WORDS):0]   waddr_i,
  input  logic [23:0]                   wdata_i,
  input  logic [$clog2(LINE_WORDS):0]   raddr_i,
  output logic [23:0]                   rdata_o
);

  logic [23:0] mem [2*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Line-buffer fetch controller: fills one line buffer from memory while the other drains to
// vga_ctrl. Define VGA_FETCH_TESTPAT_EN to add test_mode_i and the color-bar generator.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int unsigned LINE_WORDS      = 512,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable_i,
  input  logic          frame_start_i,
  input  logic [31:0]   base_addr_i,
  input  logic [9:0]    hpix_i,
  input  logic [9:0]    vlines_i,
  input  logic          data_req_i,
`ifdef VGA_FETCH_TESTPAT_EN
  input  logic          test_mode_i,
`endif
  output logic [11:0]   pix_o,
  output logic          underrun_o,
  vga_line_fetch_if.master bus
);

  localparam int unsigned AW = $clog2(LINE_WORDS);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  fill_state_e   st_q, st_d;
  logic [9:0]    line_q;
  logic [31:0]   addr_q;
  logic          hold_q;
  logic [AW:0]   issued_q;
  logic [AW-1:0] wr_ptr_q;
  logic [OW-1:0] outst_q;
  logic          fill_sel_q;
  logic          restart_pend_q, restart_pend_d;
  logic          disp_sel_q, disp_sel_d;
  logic [1:0]    valid_q, valid_d;
  logic [9:0]    pidx_q, pidx_d;
  logic          underrun_q, underrun_d;

  logic          test_mode;
  logic [9:0]    words;
  logic [AW-1:0] last_word;
  logic          can_issue, gnt, busy, abort, line_done, init;
  logic [23:0]   rdata;
  logic [11:0]   buf_pix;
  logic          unused_bits;

`ifdef VGA_FETCH_TESTPAT_EN
  assign test_mode = test_mode_i;
`else
  assign test_mode = 1'b0;
`endif

  assign words     = hpix_i / 10'(PIX_PER_WORD);
  assign last_word = AW'(words - 10'd1);

  assign can_issue = (st_q == StFill) && (10'(issued_q) < words) &&
                     (outst_q < OW'(MAX_OUTSTANDING)) && !test_mode;
  // A request once raised stays up until granted, even after an abort
  assign bus.rd_req  = hold_q | can_issue;
  assign bus.rd_addr = addr_q;
  assign gnt         = bus.rd_req & bus.rd_gnt;

  assign busy      = (outst_q != '0) || bus.rd_req;
  assign abort     = ((st_q == StFill) || (st_q == StFull)) && (frame_start_i || !enable_i);
  assign line_done = (st_q == StFill) && bus.rd_valid && (wr_ptr_q == last_word) && !abort;

  always_comb begin
    st_d           = st_q;
    init           = 1'b0;
    restart_pend_d = restart_pend_q;
    unique case (st_q)
      StIdle: begin
        if (frame_start_i && enable_i) begin
          st_d = StFill;
          init = 1'b1;
        end
      end
      StFill: begin
        if (line_done) st_d = StFull;
      end
      StFull: begin
        if (!valid_q[fill_sel_q] && (line_q < vlines_i)) st_d = StFill;
      end
      StDrain: begin
        if (frame_start_i) begin
          restart_pend_d = 1'b1;
        end else if (!busy) begin
          restart_pend_d = 1'b0;
          if (restart_pend_q && enable_i) begin
            st_d = StFill;
            init = 1'b1;
          end else begin
            st_d = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase

    if (abort) begin
      if (busy) begin
        st_d           = StDrain;
        restart_pend_d = frame_start_i;
      end else if (frame_start_i && enable_i) begin
        st_d = StFill;
        init = 1'b1;
      end else begin
        st_d = StIdle;
      end
    end
  end

  // Display side: pixel index, buffer select and validity
  always_comb begin
    pidx_d     = pidx_q;
    disp_sel_d = disp_sel_q;
    valid_d    = valid_q;
    underrun_d = underrun_q;
    if (frame_start_i || init) begin
      pidx_d     = '0;
      disp_sel_d = 1'b0;
      valid_d    = '0;
    end else begin
      if (data_req_i) begin
        if (!valid_q[disp_sel_q] && !test_mode) underrun_d = 1'b1;
        if (pidx_q == hpix_i - 10'd1) begin
          pidx_d              = '0;
          disp_sel_d          = ~disp_sel_q;
          valid_d[disp_sel_q] = 1'b0;
        end else begin
          pidx_d = pidx_q + 10'd1;
        end
      end
      if (line_done) valid_d[fill_sel_q] = 1'b1;
    end
    if (frame_start_i) underrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q           <= StIdle;
      line_q         <= '0;
      addr_q         <= '0;
      hold_q         <= 1'b0;
      issued_q       <= '0;
      wr_ptr_q       <= '0;
      outst_q        <= '0;
      fill_sel_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      disp_sel_q     <= 1'b0;
      valid_q        <= '0;
      pidx_q         <= '0;
      underrun_q     <= 1'b0;
    end else begin
      st_q           <= st_d;
      restart_pend_q <= restart_pend_d;
      hold_q         <= bus.rd_req & ~bus.rd_gnt;
      outst_q        <= outst_q + OW'(gnt) - OW'(bus.rd_valid);
      disp_sel_q     <= disp_sel_d;
      valid_q        <= valid_d;
      pidx_q         <= pidx_d;
      underrun_q     <= underrun_d;
      if (init) begin
        line_q     <= '0;
        addr_q     <= base_addr_i;
        issued_q   <= '0;
        wr_ptr_q   <= '0;
        fill_sel_q <= 1'b0;
      end else begin
        if (gnt) addr_q <= addr_q + 32'(BYTES_PER_WORD);
        if (line_done) begin
          issued_q   <= '0;
          wr_ptr_q   <= '0;
          line_q     <= line_q + 10'd1;
          fill_sel_q <= ~fill_sel_q;
        end else begin
          if (gnt && (st_q == StFill)) issued_q <= issued_q + 1'b1;
          if (bus.rd_valid && (st_q == StFill)) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
    end
  end

  // Read address follows the next pixel so word and buffer boundaries have no bubble
  vga_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk     (clk),
    .we_i    ((st_q == StFill) && bus.rd_valid),
    .waddr_i ({fill_sel_q, wr_ptr_q}),
    .wdata_i ({bus.rd_data[27:16], bus.rd_data[11:0]}),
    .raddr_i ({disp_sel_d, AW'(pidx_d >> 1)}),
    .rdata_o (rdata)
  );

  assign buf_pix     = pidx_q[0] ? rdata[23:12] : rdata[11:0];
  assign unused_bits = ^{bus.rd_data[31:28], bus.rd_data[15:12]};

`ifdef VGA_FETCH_TESTPAT_EN
  logic [12:0] bar_num;
  assign bar_num = {pidx_q, 3'b000} / {3'b000, hpix_i};
  assign pix_o   = test_mode_i ? bar_color(bar_num[2:0]) :
                   (valid_q[disp_sel_q] ? buf_pix : 12'h000);
`else
  assign pix_o = valid_q[disp_sel_q] ? buf_pix : 12'h000;
`endif

  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: bus responder with configurable latency and grant budget,
// table-driven display checks and hand-written abort/stall sequences.
module tb_vga_line_fetch;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable_i;
  logic        frame_start_i;
  logic [31:0] base_addr_i;
  logic [9:0]  hpix_i;
  logic [9:0]  vlines_i;
  logic        data_req_i;
  logic [11:0] pix_o;
  logic        underrun_o;
`ifdef VGA_FETCH_TESTPAT_EN
  logic        test_mode_i;
`endif

  vga_line_fetch_if bus ();

  vga_line_fetch dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable_i      (enable_i),
    .frame_start_i (frame_start_i),
    .base_addr_i   (base_addr_i),
    .hpix_i        (hpix_i),
    .vlines_i      (vlines_i),
    .data_req_i    (data_req_i),
`ifdef VGA_FETCH_TESTPAT_EN
    .test_mode_i   (test_mode_i),
`endif
    .pix_o         (pix_o),
    .underrun_o    (underrun_o),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Pixel n of the frame (counted from 0x1000) holds 0x100 + n
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] p;
    p = 12'((a - 32'h1000) >> 1);
    return {4'h0, 12'h100 + p + 12'd1, 4'h0, 12'h100 + p};
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  rd_t         rq[$];
  logic [31:0] glog[$];
  int          lat        = 1;
  int          gnt_budget = 1000000;
  int          cyc        = 0;
  int          max_out    = 0;

  // Memory responder: returns in order, lat cycles after the grant cycle
  initial begin
    rd_t e;
    rd_t r;
    bus.rd_gnt   = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.rd_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r            = rq.pop_front();
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem_word(r.addr);
      end
      bus.rd_gnt = 1'b0;
      if (resetn === 1'b1 && bus.rd_req === 1'b1 && gnt_budget > 0) begin
        bus.rd_gnt = 1'b1;
        gnt_budget--;
        e.addr = bus.rd_addr;
        e.due  = cyc + lat;
        rq.push_back(e);
        glog.push_back(bus.rd_addr);
      end
      if (rq.size() > max_out) max_out = rq.size();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_frame_start();
    frame_start_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
  endtask

  task automatic wait_full(input int n_grants, input int budget, input string name);
    int k = 0;
    while (!(glog.size() >= n_grants && dut.st_q == StFull && bus.rd_req == 1'b0) &&
           k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, 32'(k < budget), 32'd1);
  endtask

  typedef struct {
    logic        req;
    logic [11:0] pix;
    logic        ur;
  } dvec_t;

  dvec_t       dtab[18];
  logic [11:0] bars[8];
  int          n;

  initial begin
    for (int i = 0; i < 16; i++) dtab[i] = '{1'b1, 12'h100 + 12'(i), 1'b0};
    dtab[16] = '{1'b1, 12'h000, 1'b0};
    dtab[17] = '{1'b0, 12'h000, 1'b1};
    bars = '{12'hFFF, 12'h0FF, 12'hFF0, 12'h0F0, 12'hF0F, 12'h00F, 12'hF00, 12'h000};

    resetn        = 1'b0;
    enable_i      = 1'b0;
    frame_start_i = 1'b0;
    base_addr_i   = '0;
    hpix_i        = 10'd8;
    vlines_i      = 10'd2;
    data_req_i    = 1'b0;
`ifdef VGA_FETCH_TESTPAT_EN
    test_mode_i   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_rd_req", 32'(bus.rd_req), 32'd0);
    check("reset_rd_addr", bus.rd_addr, 32'd0);
    check("reset_pix", 32'(pix_o), 32'd0);
    check("reset_underrun", 32'(underrun_o), 32'd0);
    check("reset_state", 32'(dut.st_q), 32'(StIdle));
    resetn = 1'b1;
    @(negedge clk);

    // Two 8-pixel lines, ideal bus
    base_addr_i = 32'h1000;
    enable_i    = 1'b1;
    lat         = 1;
    pulse_frame_start();
    n = 1;
    while (pix_o == 12'h000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_line_ready_cycles", 32'(n), 32'd6);
    wait_full(8, 100, "fill_two_lines");
    check("grant_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check($sformatf("grant_addr[%0d]", i), glog[i], 32'h1000 + 32'(4 * i));
    check("state_full", 32'(dut.st_q), 32'(StFull));

    // Display 16 pixels across the buffer swap, then one underrun
    for (int i = 0; i < 18; i++) begin
      check($sformatf("disp_pix[%0d]", i), 32'(pix_o), 32'(dtab[i].pix));
      check($sformatf("disp_underrun[%0d]", i), 32'(underrun_o), 32'(dtab[i].ur));
      data_req_i = dtab[i].req;
      @(negedge clk);
    end
    data_req_i = 1'b0;

    // Latency 10: outstanding limit and underrun before line 0 is ready
    lat      = 10;
    hpix_i   = 10'd16;
    vlines_i = 10'd1;
    glog.delete();
    max_out  = 0;
    pulse_frame_start();
    check("underrun_cleared", 32'(underrun_o), 32'd0);
    check("pix_not_ready", 32'(pix_o), 32'd0);
    data_req_i = 1'b1;
    @(negedge clk);
    data_req_i = 1'b0;
    check("underrun_early_req", 32'(underrun_o), 32'd1);
    check("pix_underrun", 32'(pix_o), 32'd0);
    wait_full(8, 300, "fill_latency");
    check("max_outstanding", 32'(max_out), 32'd4);
    check("lat_grant_count", 32'(glog.size()), 32'd8);
    if (glog.size() >= 8) check("lat_last_addr", glog[7], 32'h101C);

    // Abort with 3 outstanding and one request held un-granted
    gnt_budget = 3;
    glog.delete();
    pulse_frame_start();
    repeat (5) @(negedge clk);
    check("pre_abort_req_held", 32'(bus.rd_req), 32'd1);
    check("pre_abort_addr", bus.rd_addr, 32'h100C);
    check("pre_abort_outstanding", 32'(rq.size()), 32'd3);
    pulse_frame_start();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_req[%0d]", i), 32'(bus.rd_req), 32'd1);
      check($sformatf("stall_addr[%0d]", i), bus.rd_addr, 32'h100C);
      @(negedge clk);
    end
    gnt_budget = 1000000;
    wait_full(12, 300, "restart_fill");
    check("restart_grant_count", 32'(glog.size()), 32'd12);
    if (glog.size() >= 12) begin
      check("held_grant_addr", glog[3], 32'h100C);
      check("restart_first_addr", glog[4], 32'h1000);
      check("restart_last_addr", glog[11], 32'h101C);
    end
    check("restart_pix0", 32'(pix_o), 32'h100);
    check("restart_underrun", 32'(underrun_o), 32'd0);

`ifdef VGA_FETCH_TESTPAT_EN
    // Color bars: no reads, no underrun
    test_mode_i = 1'b1;
    hpix_i      = 10'd16;
    glog.delete();
    pulse_frame_start();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("bar_pix[%0d]", i), 32'(pix_o), 32'(bars[i/2]));
      check($sformatf("bar_no_req[%0d]", i), 32'(bus.rd_req), 32'd0);
      data_req_i = 1'b1;
      @(negedge clk);
    end
    data_req_i = 1'b0;
    check("bar_underrun", 32'(underrun_o), 32'd0);
    check("bar_grants", 32'(glog.size()), 32'd0);
    test_mode_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
